// File: rtl/game_fsm_pkg.sv
// rtl/game_fsm_pkg.sv - state codes and state type shared by the game-flow blocks
//
// Purpose : one place for the 3-bit game state encoding seen by the
//           renderer, HUD and collision logic.
// Ports   : none (package).

package game_fsm_pkg;

    localparam int STATE_W = 3;

    // Encoded values are visible on the state output; keep them stable.
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_PLAYING = 3'd1;
    localparam logic [STATE_W-1:0] ST_OVER    = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSED  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DYING   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_PLAYING = ST_PLAYING,
        S_OVER    = ST_OVER,
        S_PAUSED  = ST_PAUSED,
        S_DYING   = ST_DYING
    } state_e;

endpackage

// File: rtl/game_fsm_tick.sv
// rtl/game_fsm_tick.sv - frame-tick driven down counter with expiry pulse
//
// Purpose : loadable down counter that steps once per unfrozen tick and
//           stops at zero.
// Ports   : clk, rst_n      clock, async active-low reset
//           load, load_val  synchronous load (wins over tick)
//           tick, hold      step request and freeze
//           count, zero     current value and count==0
//           expire          combinational pulse in the cycle whose tick
//                           moves count from 1 to 0, so the owner can act
//                           on the same edge the counter reaches zero

module tick_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic         step;

    assign step = tick & ~hold & ~load & (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (step) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count  = count_q;
    assign zero   = (count_q == '0);
    assign expire = step & (count_q == W'(1));

endmodule

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - game-flow state machine with lives, pause, death and invulnerability
//
// Purpose : takes every game-flow decision between input/collision logic and
//           the renderer/HUD. Timing advances only on frame_tick.
// Ports   : clk, rst_n   clock, async active-low reset
//           frame_tick   one-cycle pulse per video frame
//           start_game   starts a game from IDLE
//           pause_btn    level; rising edge toggles pause
//           hit          collision pulse
//           restart      returns to IDLE from any state
//           state        IDLE=0 PLAYING=1 OVER=2 PAUSED=3 DYING=4
//           lives        remaining lives
//           invuln       high while the invulnerability timer is nonzero
//           score        saturating count of frame ticks spent in PLAYING
//           state_chg    one-cycle pulse after every state transition

module game_fsm
    import game_fsm_pkg::*;
#(
    parameter int MAX_LIVES    = 3,
    parameter int LIVES_W      = 2,
    parameter int DEATH_TICKS  = 30,
    parameter int INVULN_TICKS = 90,
    parameter int TMR_W        = 8,
    parameter int SCORE_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_game,
    input  logic               pause_btn,
    input  logic               hit,
    input  logic               restart,
    output logic [STATE_W-1:0] state,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln,
    output logic [SCORE_W-1:0] score,
    output logic               state_chg
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
    localparam logic [TMR_W-1:0]   DEATH_LD   = TMR_W'(DEATH_TICKS);
    localparam logic [TMR_W-1:0]   INVULN_LD  = TMR_W'(INVULN_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    state_e             state_q;
    state_e             state_d;
    logic [LIVES_W-1:0] lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               invuln_q;
    logic               state_chg_q;
    logic               pause_q;
    logic               pause_edge;

    logic               d_load;
    logic [TMR_W-1:0]   d_val;
    logic               i_load;
    logic [TMR_W-1:0]   i_val;
    logic               dec_lives;
    logic               new_game;
    logic               respawn;
    logic               timers_hold;

    logic [TMR_W-1:0]   d_count;
    logic [TMR_W-1:0]   i_count;
    logic               d_zero;
    logic               i_zero;
    logic               d_expire;
    logic               i_expire;

    // pause_q follows the button every cycle, so a button held across a
    // state change never looks like a fresh edge.
    assign pause_edge = pause_btn & ~pause_q;

    // Both timers freeze while paused; outside their owning state they sit
    // at zero, so no further gating is needed.
    assign timers_hold = (state_q == S_PAUSED);

    tick_down_counter #(.W(TMR_W)) u_death_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (d_load),
        .load_val (d_val),
        .tick     (frame_tick),
        .hold     (timers_hold),
        .count    (d_count),
        .zero     (d_zero),
        .expire   (d_expire)
    );

    tick_down_counter #(.W(TMR_W)) u_invuln_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (i_load),
        .load_val (i_val),
        .tick     (frame_tick),
        .hold     (timers_hold),
        .count    (i_count),
        .zero     (i_zero),
        .expire   (i_expire)
    );

    // Timer values and zero flags are not needed here; the expiry pulses
    // carry everything the state machine acts on.
    logic unused_tmr;
    assign unused_tmr = ^{d_count, i_count, d_zero, i_zero};

    // Decision logic in priority order: restart > hit > pause edge >
    // start_game > timer expiry. Each state only looks at the inputs it
    // honours, which realises the per-state "ignored" rules.
    always_comb begin
        state_d   = state_q;
        d_load    = 1'b0;
        d_val     = '0;
        i_load    = 1'b0;
        i_val     = '0;
        dec_lives = 1'b0;
        new_game  = 1'b0;
        respawn   = 1'b0;
        if (restart) begin
            state_d = S_IDLE;
            d_load  = 1'b1;
            i_load  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_game) begin
                        state_d  = S_PLAYING;
                        new_game = 1'b1;
                        d_load   = 1'b1;
                        i_load   = 1'b1;
                    end
                end
                S_PLAYING: begin
                    // A qualifying hit consumes a same-cycle pause edge.
                    if (hit && !invuln_q) begin
                        state_d   = S_DYING;
                        dec_lives = 1'b1;
                        d_load    = 1'b1;
                        d_val     = DEATH_LD;
                    end else if (pause_edge) begin
                        state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (pause_edge) begin
                        state_d = S_PLAYING;
                    end
                end
                S_DYING: begin
                    // lives was already decremented when the hit landed.
                    if (d_expire) begin
                        if (lives_q == '0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_PLAYING;
                            respawn = 1'b1;
                            i_load  = 1'b1;
                            i_val   = INVULN_LD;
                        end
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lives_q     <= LIVES_INIT;
            score_q     <= '0;
            invuln_q    <= 1'b0;
            state_chg_q <= 1'b0;
            pause_q     <= 1'b0;
        end else begin
            pause_q     <= pause_btn;
            state_q     <= state_d;
            state_chg_q <= (state_d != state_q);

            if (new_game) begin
                lives_q <= LIVES_INIT;
                score_q <= '0;
            end else begin
                if (dec_lives) begin
                    lives_q <= lives_q - 1'b1;
                end
                // A tick still scores in the cycle PLAYING is left by a hit
                // or pause; restart freezes the score as-is.
                if (state_q == S_PLAYING && frame_tick && !restart &&
                    score_q != SCORE_MAX) begin
                    score_q <= score_q + 1'b1;
                end
            end

            // Mirrors "invuln timer nonzero" without a combinational output.
            if (restart || new_game) begin
                invuln_q <= 1'b0;
            end else if (respawn) begin
                invuln_q <= 1'b1;
            end else if (i_expire) begin
                invuln_q <= 1'b0;
            end
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign invuln    = invuln_q;
    assign score     = score_q;
    assign state_chg = state_chg_q;

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - directed self-checking bench for game_fsm

module tb_game_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        start_game;
    logic        pause_btn;
    logic        hit;
    logic        restart;

    logic [2:0]  state;
    logic [1:0]  lives;
    logic        invuln;
    logic [15:0] score;
    logic        state_chg;

    logic [2:0]  s_state;
    logic [1:0]  s_lives;
    logic        s_invuln;
    logic [3:0]  s_score;
    logic        s_state_chg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_fsm #(
        .MAX_LIVES(3), .LIVES_W(2), .DEATH_TICKS(4), .INVULN_TICKS(8),
        .TMR_W(8), .SCORE_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .start_game(start_game), .pause_btn(pause_btn), .hit(hit),
        .restart(restart), .state(state), .lives(lives), .invuln(invuln),
        .score(score), .state_chg(state_chg)
    );

    game_fsm #(
        .MAX_LIVES(3), .LIVES_W(2), .DEATH_TICKS(4), .INVULN_TICKS(8),
        .TMR_W(8), .SCORE_W(4)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .start_game(start_game), .pause_btn(pause_btn), .hit(hit),
        .restart(restart), .state(s_state), .lives(s_lives), .invuln(s_invuln),
        .score(s_score), .state_chg(s_state_chg)
    );

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; frame_tick = 1'b1; start_game = 1'b0;
        pause_btn = 1'b0; hit = 1'b0; restart = 1'b0;
        step(2);
        checks++; if (state !== 3'd0 || lives !== 2'd3 || score !== 16'd0 || invuln !== 1'b0 || state_chg !== 1'b0) begin
            errors++; $display("FAIL reset_vals got st=%0d lv=%0d sc=%0d iv=%0d chg=%0d exp 0 3 0 0 0", state, lives, score, invuln, state_chg);
        end
        rst_n = 1'b1;
        start_game = 1'b1; step(1); start_game = 1'b0;
        step(20);
        checks++; if (state !== 3'd1 || score !== 16'd20) begin
            errors++; $display("FAIL pre_reset got st=%0d sc=%0d exp 1 20", state, score);
        end
        rst_n = 1'b0; #2;
        checks++; if (state !== 3'd0 || lives !== 2'd3 || score !== 16'd0 || invuln !== 1'b0) begin
            errors++; $display("FAIL async_reset got st=%0d lv=%0d sc=%0d iv=%0d exp 0 3 0 0", state, lives, score, invuln);
        end
        rst_n = 1'b1;
        start_game = 1'b1; step(1); start_game = 1'b0;
        checks++; if (state !== 3'd1 || state_chg !== 1'b1) begin
            errors++; $display("FAIL start got st=%0d chg=%0d exp 1 1", state, state_chg);
        end
        step(1);
        checks++; if (state !== 3'd1 || state_chg !== 1'b0 || score !== 16'd1) begin
            errors++; $display("FAIL start_settle got st=%0d chg=%0d sc=%0d exp 1 0 1", state, state_chg, score);
        end
    endtask

    task automatic test_hit_invuln;
        hit = 1'b1; step(1); hit = 1'b0;
        checks++; if (state !== 3'd4 || lives !== 2'd2 || state_chg !== 1'b1) begin
            errors++; $display("FAIL hit got st=%0d lv=%0d chg=%0d exp 4 2 1", state, lives, state_chg);
        end
        step(3);
        checks++; if (state !== 3'd4) begin
            errors++; $display("FAIL dying_3ticks got st=%0d exp 4", state);
        end
        step(1);
        checks++; if (state !== 3'd1 || invuln !== 1'b1 || state_chg !== 1'b1) begin
            errors++; $display("FAIL respawn got st=%0d iv=%0d chg=%0d exp 1 1 1", state, invuln, state_chg);
        end
        step(2);
        hit = 1'b1; step(1); hit = 1'b0;
        checks++; if (state !== 3'd1 || lives !== 2'd2) begin
            errors++; $display("FAIL invuln_hit got st=%0d lv=%0d exp 1 2", state, lives);
        end
        step(4);
        checks++; if (invuln !== 1'b1) begin
            errors++; $display("FAIL invuln_tick7 got %0d exp 1", invuln);
        end
        step(1);
        checks++; if (invuln !== 1'b0) begin
            errors++; $display("FAIL invuln_tick8 got %0d exp 0", invuln);
        end
    endtask

    task automatic test_game_over;
        restart = 1'b1; step(1); restart = 1'b0;
        start_game = 1'b1; step(1); start_game = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1; step(1); hit = 1'b0;
            checks++; if (lives !== 2'(2 - i) || state !== 3'd4) begin
                errors++; $display("FAIL over_hit%0d got lv=%0d st=%0d exp %0d 4", i, lives, state, 2 - i);
            end
            step(4);
            if (i < 2) begin
                checks++; if (state !== 3'd1) begin
                    errors++; $display("FAIL over_respawn%0d got st=%0d exp 1", i, state);
                end
                step(8);
            end
        end
        checks++; if (state !== 3'd2 || lives !== 2'd0) begin
            errors++; $display("FAIL over got st=%0d lv=%0d exp 2 0", state, lives);
        end
        start_game = 1'b1; step(1); start_game = 1'b0;
        checks++; if (state !== 3'd2 || state_chg !== 1'b0) begin
            errors++; $display("FAIL over_start got st=%0d chg=%0d exp 2 0", state, state_chg);
        end
        restart = 1'b1; step(1); restart = 1'b0;
        checks++; if (state !== 3'd0 || state_chg !== 1'b1) begin
            errors++; $display("FAIL over_restart got st=%0d chg=%0d exp 0 1", state, state_chg);
        end
        start_game = 1'b1; step(1); start_game = 1'b0;
        checks++; if (state !== 3'd1 || lives !== 2'd3 || score !== 16'd0) begin
            errors++; $display("FAIL new_game got st=%0d lv=%0d sc=%0d exp 1 3 0", state, lives, score);
        end
    endtask

    task automatic test_pause;
        step(10);
        frame_tick = 1'b0; pause_btn = 1'b1; step(1); frame_tick = 1'b1;
        checks++; if (state !== 3'd3 || score !== 16'd10) begin
            errors++; $display("FAIL pause got st=%0d sc=%0d exp 3 10", state, score);
        end
        step(50);
        checks++; if (state !== 3'd3 || score !== 16'd10) begin
            errors++; $display("FAIL pause_frozen got st=%0d sc=%0d exp 3 10", state, score);
        end
        hit = 1'b1; step(1); hit = 1'b0;
        checks++; if (state !== 3'd3 || lives !== 2'd3) begin
            errors++; $display("FAIL pause_hit got st=%0d lv=%0d exp 3 3", state, lives);
        end
        pause_btn = 1'b0; step(1); pause_btn = 1'b1; step(1);
        checks++; if (state !== 3'd1 || score !== 16'd10 || state_chg !== 1'b1) begin
            errors++; $display("FAIL unpause got st=%0d sc=%0d chg=%0d exp 1 10 1", state, score, state_chg);
        end
        step(1);
        checks++; if (state !== 3'd1 || score !== 16'd11) begin
            errors++; $display("FAIL resume got st=%0d sc=%0d exp 1 11", state, score);
        end
        step(3);
        checks++; if (state !== 3'd1 || score !== 16'd14) begin
            errors++; $display("FAIL held_btn got st=%0d sc=%0d exp 1 14", state, score);
        end
        pause_btn = 1'b0; step(1);
    endtask

    task automatic test_same_cycle;
        hit = 1'b1; pause_btn = 1'b1; step(1); hit = 1'b0;
        checks++; if (state !== 3'd4 || lives !== 2'd2) begin
            errors++; $display("FAIL hit_pause got st=%0d lv=%0d exp 4 2", state, lives);
        end
        step(4);
        checks++; if (state !== 3'd1) begin
            errors++; $display("FAIL hit_pause_respawn got st=%0d exp 1", state);
        end
        pause_btn = 1'b0;
        step(8);
        checks++; if (invuln !== 1'b0) begin
            errors++; $display("FAIL pre_restart_invuln got %0d exp 0", invuln);
        end
        restart = 1'b1; hit = 1'b1; step(1); restart = 1'b0; hit = 1'b0;
        checks++; if (state !== 3'd0 || lives !== 2'd2) begin
            errors++; $display("FAIL restart_hit got st=%0d lv=%0d exp 0 2", state, lives);
        end
        restart = 1'b1; step(1); restart = 1'b0;
        checks++; if (state !== 3'd0 || state_chg !== 1'b0) begin
            errors++; $display("FAIL idle_restart got st=%0d chg=%0d exp 0 0", state, state_chg);
        end
    endtask

    task automatic test_saturate_and_dying_restart;
        logic quiet;
        start_game = 1'b1; step(1); start_game = 1'b0;
        step(20);
        checks++; if (s_score !== 4'd15 || score !== 16'd20) begin
            errors++; $display("FAIL saturate got s=%0d w=%0d exp 15 20", s_score, score);
        end
        hit = 1'b1; step(1); hit = 1'b0;
        checks++; if (score !== 16'd21 || state !== 3'd4) begin
            errors++; $display("FAIL hit_tick_score got sc=%0d st=%0d exp 21 4", score, state);
        end
        step(2);
        restart = 1'b1; step(1); restart = 1'b0;
        checks++; if (state !== 3'd0 || state_chg !== 1'b1 || lives !== 2'd2 || score !== 16'd21) begin
            errors++; $display("FAIL dying_restart got st=%0d chg=%0d lv=%0d sc=%0d exp 0 1 2 21", state, state_chg, lives, score);
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (state !== 3'd0 || state_chg !== 1'b0 || s_state !== 3'd0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin
            errors++; $display("FAIL no_late_expiry got st=%0d chg=%0d exp 0 0", state, state_chg);
        end
    endtask

    initial begin
        test_reset();
        test_hit_invuln();
        test_game_over();
        test_pause();
        test_same_cycle();
        test_saturate_and_dying_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
